// File: rtl/pc_pkg.sv
// Shared encodings for the PC sequencer: the pc_sel values, the FSM states and the default width.
// The return-address stack is optional and is built only when PC_SEQ_RAS_EN is defined.
package pc_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JALR   = 2'b10,
        SEL_TRAP   = 2'b11
    } pc_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack built as a circular buffer with a top pointer and an entry count.
// A push into a full stack overwrites the oldest entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            Areset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, wr_ptr;
    logic [PW:0]     cnt_q, cnt_d;
    logic            wr_en;

    assign empty = (cnt_q == '0);
    assign top   = empty ? '0 : mem_q[ptr_q];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = ptr_q + 1'b1;
        if (push && (!pop || empty)) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != (PW+1)'(DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (push && pop) begin
            wr_en  = 1'b1;
            wr_ptr = ptr_q;
        end else if (pop && !empty) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge Areset) begin
        if (Areset) begin
            ptr_q <= '1;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the storage array has no reset; the count alone defines validity and top is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a RUN/HALT FSM, misaligned-target detection and an optional
// return-address stack enabled by the PC_SEQ_RAS_EN macro.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            Areset,
    input  logic            load,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] target, jalr_sum;
    logic            ras_act;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = rs1 + imm;

    always_comb begin
        target = pc_plus4;
        case (pc_sel_e'(pc_sel))
            SEL_SEQ:    target = pc_plus4;
            SEL_BRANCH: target = pc_q + imm;
            SEL_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
            SEL_TRAP:   target = trap_vec;
            default:    target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        ras_act    = 1'b0;
        if (load) begin
            case (state_q)
                ST_RUN: begin
                    ras_act = 1'b1;
                    // A trap is always taken, even to a misaligned handler address.
                    if (pc_sel_e'(pc_sel) != SEL_TRAP && is_misaligned(target[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d = target;
                    end
                end
                ST_HALT: begin
                    if (pc_sel_e'(pc_sel) == SEL_TRAP) begin
                        pc_d       = trap_vec;
                        misalign_d = 1'b0;
                        state_d    = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge Areset) begin
        if (Areset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign halted   = (state_q == ST_HALT);
    assign misalign = misalign_q;

`ifdef PC_SEQ_RAS_EN
    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk    (clk),
        .Areset (Areset),
        .push   (ras_push & ras_act),
        .pop    (ras_pop & ras_act),
        .din    (pc_plus4),
        .top    (ras_top),
        .empty  (ras_empty)
    );
`else
    logic unused_ras;
    assign unused_ras = ras_push ^ ras_pop ^ ras_act;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
`endif

endmodule
